// File: rtl/key_led_ctrl.sv
// Board key/LED controller: debounced key presses select an LED pattern mode and
// a step speed; a step tick drives off / on / blink / chase patterns.
module key_led_ctrl #(
  parameter int NUM_KEYS        = 2,
  parameter int NUM_LEDS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_CYCLES     = 25000000,
  parameter int KEY_ACTIVE_LOW  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_LEDS-1:0] led,
  output logic [1:0]          mode,
  output logic [1:0]          speed,
  output logic [NUM_KEYS-1:0] press
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CHASE = 2'd3
  } mode_t;

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam logic [NUM_KEYS-1:0] RAW_RELEASED = (KEY_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [DB_W-1:0]     DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_LEDS-1:0] CHASE_START  = NUM_LEDS'(1);

  logic [NUM_KEYS-1:0] s1, s2, level, db, db_q;
  logic [DB_W-1:0]     db_cnt [NUM_KEYS];

  mode_t               mode_q;
  logic [1:0]          speed_q;
  logic [STEP_W-1:0]   step_cnt, step_last;
  logic                tick, speed_inc, blink_on;
  logic [NUM_LEDS-1:0] chase;

  // Normalise after synchronisation so 1 always means pressed.
  assign level = (KEY_ACTIVE_LOW != 0) ? ~s2 : s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= RAW_RELEASED;
      s2    <= RAW_RELEASED;
      db    <= '0;
      db_q  <= '0;
      press <= '0;
      for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
    end else begin
      s1    <= key;
      s2    <= s1;
      db_q  <= db;
      press <= db & ~db_q;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (level[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  if (NUM_KEYS >= 2) begin : g_speed_key
    assign speed_inc = press[1];
  end else begin : g_no_speed_key
    assign speed_inc = 1'b0;
  end

  assign step_last = STEP_W'((STEP_CYCLES >> speed_q) - 1);
  assign tick      = (step_cnt == step_last);

  // A key-driven change restarts the step period; pattern state only
  // advances on ticks that are not coincident with such a change.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_OFF;
      speed_q  <= 2'd0;
      step_cnt <= '0;
      blink_on <= 1'b0;
      chase    <= CHASE_START;
      led      <= '0;
    end else begin
      if (press[0]) mode_q <= mode_t'(mode_q + 2'd1);
      if (speed_inc) speed_q <= speed_q + 2'd1;

      if (press[0] || speed_inc || tick) step_cnt <= '0;
      else step_cnt <= step_cnt + STEP_W'(1);

      if (press[0]) begin
        blink_on <= 1'b1;
        chase    <= CHASE_START;
      end else if (tick && !speed_inc) begin
        if (mode_q == MODE_BLINK) blink_on <= ~blink_on;
        if (mode_q == MODE_CHASE) chase <= {chase[NUM_LEDS-2:0], chase[NUM_LEDS-1]};
      end

      case (mode_q)
        MODE_OFF:   led <= '0;
        MODE_ON:    led <= '1;
        MODE_BLINK: led <= {NUM_LEDS{blink_on}};
        MODE_CHASE: led <= chase;
        default:    led <= '0;
      endcase
    end
  end

  assign mode  = mode_q;
  assign speed = speed_q;

endmodule
